// File: rtl/pipearch_update_if.sv
// rtl/pipearch_update_if.sv - FIFO/BRAM port bundle shared by the pipearch stages
//
// fifobram_interface groups the handshake of a FIFO read port or a BRAM
// read/write port. DATA_W sets the data width (512 for lines, 32 for the
// scalar FIFO); ADDR_W sets the BRAM address width.
//   fifo_read  : re out; rvalid, rdata, empty in (rdata valid one cycle after re)
//   bram_read  : re, raddr out; rdata in (one cycle read latency)
//   bram_write : we, waddr, wdata out
interface fifobram_interface #(
    parameter int DATA_W = 512,
    parameter int ADDR_W = 16
);
    logic              re;
    logic              rvalid;
    logic              empty;
    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] raddr;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;

    modport fifo_read  (output re, input rvalid, input rdata, input empty);
    modport bram_read  (output re, output raddr, input rdata);
    modport bram_write (output we, output waddr, output wdata);
endinterface

// File: rtl/pipearch_update.sv
// rtl/pipearch_update.sv - SGD model update stage: model[i] -= (scalar*sample[i]) >>> shift
//
// Reads one scalar per operation, then streams sample lines alongside the
// matching model lines and writes model - ((scalar*sample) >>> shift) back,
// per signed 32-bit lane, 16 lanes per 512-bit line.
// Ports:
//   clk, reset       clock, asynchronous active-high reset
//   op_start         start pulse (accepted only when idle)
//   op_done          one-cycle completion pulse
//   regs0            [15:0] num_lines, [20:16] shift
//   regs1            [15:0] model base offset
//   samples_input    sample line FIFO (512-bit)
//   scalar_input     scalar FIFO, value in rdata[31:0]
//   modelMem_input   model BRAM read port
//   modelMem_output  model BRAM write port
// Build option: PIPEARCH_UPDATE_SATURATE_EN clamps the shifted product and
// saturates the subtraction instead of wrapping; latency is unchanged.
module pipearch_update #(
    parameter int LANES  = 16,
    parameter int ADDR_W = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      op_start,
    output logic                      op_done,
    input  logic [31:0]               regs0,
    input  logic [31:0]               regs1,
    fifobram_interface.fifo_read      samples_input,
    fifobram_interface.fifo_read      scalar_input,
    fifobram_interface.bram_read      modelMem_input,
    fifobram_interface.bram_write     modelMem_output
);
    typedef enum logic [1:0] {S_IDLE, S_SCALAR, S_STREAM, S_DRAIN} state_t;

    state_t                 state_q, state_d;
    logic [15:0]            num_lines_q, num_lines_d;
    logic [4:0]             shift_q, shift_d;
    logic [ADDR_W-1:0]      offset_q, offset_d;
    logic [15:0]            req_q, req_d;
    logic [15:0]            wr_q, wr_d;
    logic [31:0]            scalar_q, scalar_d;
    logic                   scalar_pend_q, scalar_pend_d;
    // Stage 1: a line read was issued last cycle; its data arrives now.
    logic                   v1_q, v1_d;
    logic [ADDR_W-1:0]      a1_q, a1_d;
    // Stage 2: registered write-back.
    logic                   we_q, we_d;
    logic [ADDR_W-1:0]      waddr_q, waddr_d;
    logic [32*LANES-1:0]    wdata_q, wdata_d;
    logic                   op_done_q, op_done_d;

    logic                   samp_re;
    logic                   scal_re;
    logic [ADDR_W-1:0]      raddr;
    logic [32*LANES-1:0]    lane_res;
    logic                   unused_bits;

    assign unused_bits = ^{regs0[31:21], regs1[31:16]};

    function automatic logic [31:0] lane_update(
        input logic [31:0] model,
        input logic [31:0] sample,
        input logic [31:0] scalar,
        input logic [4:0]  shift
    );
        logic signed [63:0] prod;
        logic signed [63:0] shifted;
`ifdef PIPEARCH_UPDATE_SATURATE_EN
        logic [31:0]        delta;
        logic signed [32:0] diff;
`endif
        prod    = $signed({{32{scalar[31]}}, scalar}) * $signed({{32{sample[31]}}, sample});
        shifted = prod >>> shift;
`ifdef PIPEARCH_UPDATE_SATURATE_EN
        // Fits in 32 bits only when the upper 33 bits are pure sign extension.
        if (shifted[63:31] == {33{shifted[63]}}) begin
            delta = shifted[31:0];
        end else begin
            delta = shifted[63] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end
        diff = $signed({model[31], model}) - $signed({delta[31], delta});
        if (diff[32] != diff[31]) begin
            return diff[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end
        return diff[31:0];
`else
        return model - shifted[31:0];
`endif
    endfunction

    always_comb begin
        lane_res = '0;
        for (int l = 0; l < LANES; l++) begin
            lane_res[l*32 +: 32] = lane_update(modelMem_input.rdata[l*32 +: 32],
                                               samples_input.rdata[l*32 +: 32],
                                               scalar_q, shift_q);
        end
    end

    assign raddr = offset_q + ADDR_W'(req_q);

    always_comb begin
        state_d       = state_q;
        num_lines_d   = num_lines_q;
        shift_d       = shift_q;
        offset_d      = offset_q;
        req_d         = req_q;
        wr_d          = wr_q + {15'd0, we_q};
        scalar_d      = scalar_q;
        scalar_pend_d = scalar_pend_q;
        op_done_d     = 1'b0;
        samp_re       = 1'b0;
        scal_re       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (op_start) begin
                    num_lines_d   = regs0[15:0];
                    shift_d       = regs0[20:16];
                    offset_d      = regs1[ADDR_W-1:0];
                    req_d         = '0;
                    wr_d          = '0;
                    scalar_pend_d = 1'b0;
                    if (regs0[15:0] == 16'd0) begin
                        op_done_d = 1'b1;
                    end else begin
                        state_d = S_SCALAR;
                    end
                end
            end
            S_SCALAR: begin
                // One read only; pend blocks a second re while data is in flight.
                if (!scalar_input.empty && !scalar_pend_q) begin
                    scal_re       = 1'b1;
                    scalar_pend_d = 1'b1;
                end
                if (scalar_pend_q && scalar_input.rvalid) begin
                    scalar_d      = scalar_input.rdata[31:0];
                    scalar_pend_d = 1'b0;
                    state_d       = S_STREAM;
                end
            end
            S_STREAM: begin
                if (!samples_input.empty && (req_q < num_lines_q)) begin
                    samp_re = 1'b1;
                    req_d   = req_q + 16'd1;
                    if (req_q + 16'd1 == num_lines_q) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // wr_d already includes a write landing this cycle, so the
                // registered op_done lands one cycle after the last we.
                if (wr_d == num_lines_q) begin
                    op_done_d = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        v1_d    = samp_re;
        a1_d    = raddr;
        we_d    = v1_q && samples_input.rvalid;
        waddr_d = we_d ? a1_q : waddr_q;
        wdata_d = we_d ? lane_res : wdata_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            num_lines_q   <= '0;
            shift_q       <= '0;
            offset_q      <= '0;
            req_q         <= '0;
            wr_q          <= '0;
            scalar_q      <= '0;
            scalar_pend_q <= 1'b0;
            v1_q          <= 1'b0;
            a1_q          <= '0;
            we_q          <= 1'b0;
            waddr_q       <= '0;
            wdata_q       <= '0;
            op_done_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            num_lines_q   <= num_lines_d;
            shift_q       <= shift_d;
            offset_q      <= offset_d;
            req_q         <= req_d;
            wr_q          <= wr_d;
            scalar_q      <= scalar_d;
            scalar_pend_q <= scalar_pend_d;
            v1_q          <= v1_d;
            a1_q          <= a1_d;
            we_q          <= we_d;
            waddr_q       <= waddr_d;
            wdata_q       <= wdata_d;
            op_done_q     <= op_done_d;
        end
    end

    assign samples_input.re      = samp_re;
    assign scalar_input.re       = scal_re;
    assign modelMem_input.re     = samp_re;
    assign modelMem_input.raddr  = raddr;
    assign modelMem_output.we    = we_q;
    assign modelMem_output.waddr = waddr_q;
    assign modelMem_output.wdata = wdata_q;
    assign op_done               = op_done_q;
endmodule

// File: tb/tb_pipearch_update.sv
// tb/tb_pipearch_update.sv - self-checking bench for pipearch_update
module tb_pipearch_update;
    logic        clk = 1'b0;
    logic        reset;
    logic        op_start;
    logic        op_done;
    logic [31:0] regs0;
    logic [31:0] regs1;

    always #5 clk = ~clk;

    fifobram_interface #(.DATA_W(512), .ADDR_W(16)) samp_if ();
    fifobram_interface #(.DATA_W(32),  .ADDR_W(16)) scal_if ();
    fifobram_interface #(.DATA_W(512), .ADDR_W(16)) mem_if ();

    pipearch_update dut (
        .clk             (clk),
        .reset           (reset),
        .op_start        (op_start),
        .op_done         (op_done),
        .regs0           (regs0),
        .regs1           (regs1),
        .samples_input   (samp_if),
        .scalar_input    (scal_if),
        .modelMem_input  (mem_if),
        .modelMem_output (mem_if)
    );

    assign samp_if.raddr = '0;
    assign samp_if.we    = 1'b0;
    assign samp_if.waddr = '0;
    assign samp_if.wdata = '0;
    assign scal_if.raddr = '0;
    assign scal_if.we    = 1'b0;
    assign scal_if.waddr = '0;
    assign scal_if.wdata = '0;
    assign mem_if.rvalid = 1'b0;
    assign mem_if.empty  = 1'b0;

    typedef struct {
        logic [15:0]  addr;
        logic [511:0] data;
        int           cyc;
    } wr_t;

    typedef struct {
        string       name;
        logic [15:0] nl;
        logic [4:0]  sh;
        logic [15:0] off;
        logic [31:0] scal;
        logic [31:0] samp;
        logic [31:0] model;
        logic [31:0] exp;
    } vec_t;

    logic [511:0] samp_mem [0:1023];
    logic [31:0]  scal_mem [0:255];
    logic [511:0] bram     [0:65535];
    int           samp_wr = 0;
    int           samp_rd = 0;
    int           scal_wr = 0;
    int           scal_rd = 0;
    logic         fifo_flush;
    int           cyc = 0;
    wr_t          wr_log [$];
    int           re_log [$];
    int           done_log [$];

    int           total = 0;
    int           bad = 0;
    int           start_cyc;
    int           base;
    int           samp_total;
    int           gap_cnt;
    int           stall_mode;
    logic [511:0] line_s [0:15];
    logic [511:0] line_m [0:15];
    logic [511:0] line_e [0:15];

    assign samp_if.empty = (samp_rd == samp_wr);
    assign scal_if.empty = (scal_rd == scal_wr);

    // FIFO/BRAM environment: one-cycle read latency, write and pulse logging.
    always @(posedge clk) begin
        cyc            <= cyc + 1;
        samp_if.rvalid <= samp_if.re;
        scal_if.rvalid <= scal_if.re;
        if (samp_if.re) begin
            samp_if.rdata <= samp_mem[samp_rd];
            samp_rd       <= samp_rd + 1;
        end
        if (scal_if.re) begin
            scal_if.rdata <= scal_mem[scal_rd];
            scal_rd       <= scal_rd + 1;
        end
        if (fifo_flush) begin
            samp_rd <= samp_wr;
            scal_rd <= scal_wr;
        end
        if (mem_if.re) begin
            mem_if.rdata <= bram[mem_if.raddr];
            re_log.push_back(cyc);
        end
        if (mem_if.we) wr_log.push_back('{mem_if.waddr, mem_if.wdata, cyc});
        if (op_done) done_log.push_back(cyc);
    end

    function automatic logic [31:0] ref_lane(input logic [31:0] m, input logic [31:0] s,
                                              input logic [31:0] x, input int sh);
        longint p;
        longint r;
        longint hi;
        longint lo;
        hi = 64'sd2147483647;
        lo = -64'sd2147483648;
        p  = longint'($signed(x)) * longint'($signed(s));
        p  = p >>> sh;
`ifdef PIPEARCH_UPDATE_SATURATE_EN
        if (p > hi) p = hi;
        if (p < lo) p = lo;
        r = longint'($signed(m)) - p;
        if (r > hi) r = hi;
        if (r < lo) r = lo;
`else
        r = longint'($signed(m)) - longint'($signed(p[31:0]));
`endif
        return r[31:0];
    endfunction

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, ".op_done"},  op_done,        0);
        check({tag, ".we"},       mem_if.we,      0);
        check({tag, ".waddr"},    mem_if.waddr,   0);
        check({tag, ".wdata"},    mem_if.wdata,   0);
        check({tag, ".samp_re"},  samp_if.re,     0);
        check({tag, ".scal_re"},  scal_if.re,     0);
        check({tag, ".model_re"}, mem_if.re,      0);
    endtask

    task automatic flush_fifos();
        fifo_flush = 1'b1;
        @(negedge clk);
        fifo_flush = 1'b0;
    endtask

    task automatic start_op(input logic [15:0] nl, input logic [4:0] sh, input logic [15:0] off,
                            input logic [31:0] scal, input int mode);
        wr_log.delete();
        re_log.delete();
        done_log.delete();
        base       = samp_wr;
        samp_total = samp_wr + int'(nl);
        gap_cnt    = 0;
        stall_mode = mode;
        for (int i = 0; i < int'(nl); i++) begin
            samp_mem[samp_wr + i] = line_s[i];
            bram[off + 16'(i)]    = line_m[i];
        end
        if (mode == 0) samp_wr = samp_total;
        scal_mem[scal_wr] = scal;
        scal_wr  = scal_wr + 1;
        regs0    = {11'd0, sh, nl};
        regs1    = {16'd0, off};
        op_start = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        op_start = 1'b0;
    endtask

    task automatic feed();
        if (samp_wr < samp_total) begin
            if (stall_mode == 1) begin
                if ($urandom_range(0, 1) == 1) samp_wr++;
            end else if (stall_mode == 2) begin
                if (samp_wr < base + 2) samp_wr++;
                else if (samp_rd == samp_wr) begin
                    gap_cnt++;
                    if (gap_cnt > 3) samp_wr = samp_total;
                end
            end else begin
                samp_wr = samp_total;
            end
        end
    endtask

    task automatic wait_done(input bit spurious, input string tag);
        for (int n = 0; n < 400; n++) begin
            if (done_log.size() != 0) break;
            op_start = spurious && (cyc == start_cyc + 2);
            if (op_start) regs0 = 32'h0000_0001;
            feed();
            @(negedge clk);
        end
        op_start = 1'b0;
        check({tag, ".done_seen"}, done_log.size() != 0, 1);
        repeat (4) @(negedge clk);
    endtask

    task automatic check_op(input string tag, input int nl, input logic [15:0] off);
        logic [15:0] a;
        check({tag, ".writes"}, wr_log.size(), nl);
        check({tag, ".dones"},  done_log.size(), 1);
        for (int i = 0; i < wr_log.size() && i < nl; i++) begin
            a = off + 16'(i);
            check($sformatf("%s.addr%0d", tag, i), wr_log[i].addr, a);
            check($sformatf("%s.data%0d", tag, i), wr_log[i].data, line_e[i]);
            if (i < re_log.size())
                check($sformatf("%s.lat%0d", tag, i), wr_log[i].cyc - re_log[i], 2);
        end
        if (done_log.size() > 0 && wr_log.size() > 0)
            check({tag, ".done_lat"}, done_log[0] - wr_log[wr_log.size()-1].cyc, 1);
    endtask

    task automatic run_vec(input vec_t t, input int mode, input bit spur, input string tag);
        for (int i = 0; i < 16; i++) begin
            line_s[i] = {16{t.samp}};
            line_m[i] = {16{t.model}};
            line_e[i] = {16{t.exp}};
        end
        start_op(t.nl, t.sh, t.off, t.scal, mode);
        wait_done(spur, tag);
        check_op(tag, int'(t.nl), t.off);
    endtask

    vec_t vt [7];
    vec_t vstall;

    initial begin
        int          scal_before;
        logic [15:0] nl;
        logic [4:0]  sh;
        logic [15:0] off;
        logic [31:0] scal, s, m;

        reset = 1'b1; op_start = 1'b0; regs0 = '0; regs1 = '0; fifo_flush = 1'b0;

        vt[0] = '{"basic",   16'd2, 5'd0,  16'h0010, 32'd2,         32'd3,         32'd10,        32'd4};
        vt[1] = '{"shneg",   16'd1, 5'd4,  16'h0020, 32'hFFFF_FFFC, 32'h0000_0100, 32'd0,         32'h40};
`ifdef PIPEARCH_UPDATE_SATURATE_EN
        vt[2] = '{"ovf",     16'd1, 5'd0,  16'h0030, 32'hFFFF_FFFF, 32'h20,        32'h7FFF_FFF0, 32'h7FFF_FFFF};
        vt[3] = '{"ovfneg",  16'd1, 5'd0,  16'h0040, 32'd1,         32'h10,        32'h8000_0005, 32'h8000_0000};
        vt[4] = '{"clamp",   16'd1, 5'd0,  16'h0050, 32'h4000_0000, 32'h4000_0000, 32'd3,         32'h8000_0004};
`else
        vt[2] = '{"ovf",     16'd1, 5'd0,  16'h0030, 32'hFFFF_FFFF, 32'h20,        32'h7FFF_FFF0, 32'h8000_0010};
        vt[3] = '{"ovfneg",  16'd1, 5'd0,  16'h0040, 32'd1,         32'h10,        32'h8000_0005, 32'h7FFF_FFF5};
        vt[4] = '{"clamp",   16'd1, 5'd0,  16'h0050, 32'h4000_0000, 32'h4000_0000, 32'd3,         32'd3};
`endif
        vt[5] = '{"sh31",    16'd2, 5'd31, 16'h0060, 32'h4000_0000, 32'd4,         32'd7,         32'd5};
        vt[6] = '{"wrap",    16'd2, 5'd0,  16'hFFFF, 32'd1,         32'd1,         32'd5,         32'd4};
        vstall = '{"stall",  16'd4, 5'd1,  16'h0100, 32'd3,         32'd2,         32'd100,       32'h61};

        repeat (3) @(negedge clk);
        check_quiet("reset");
        reset = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 7; v++) run_vec(vt[v], 0, 1'b0, vt[v].name);

        run_vec(vstall, 2, 1'b0, "stall");

        // Zero-length op: done right after start, scalar left in place.
        scal_before = scal_rd;
        start_op(16'd0, 5'd0, 16'h0200, 32'd5, 0);
        wait_done(1'b0, "zero");
        check("zero.dones",    done_log.size(), 1);
        if (done_log.size() > 0) check("zero.done_cyc", done_log[0] - start_cyc, 1);
        check("zero.scal_rd",  scal_rd, scal_before);
        check("zero.re",       re_log.size(), 0);
        check("zero.we",       wr_log.size(), 0);
        flush_fifos();

        // Reset after the second of eight writes.
        for (int i = 0; i < 16; i++) begin
            line_s[i] = {16{32'd1}};
            line_m[i] = {16{32'd9}};
        end
        start_op(16'd8, 5'd0, 16'h0300, 32'd1, 0);
        for (int n = 0; n < 100 && wr_log.size() < 2; n++) @(negedge clk);
        check("midreset.reached", wr_log.size(), 2);
        reset = 1'b1;
        #1;
        check_quiet("midreset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        flush_fifos();
        repeat (20) @(negedge clk);
        check("midreset.writes", wr_log.size(), 2);
        check("midreset.dones",  done_log.size(), 0);
        run_vec(vt[0], 0, 1'b0, "post_reset");

        // Randomized ops against the reference model.
        for (int k = 0; k < 25; k++) begin
            nl   = 16'($urandom_range(1, 8));
            sh   = 5'($urandom_range(0, 31));
            off  = 16'($urandom);
            scal = (k % 2 == 0) ? 32'(int'($urandom_range(0, 4095)) - 2048) : $urandom;
            for (int i = 0; i < 16; i++) begin
                for (int l = 0; l < 16; l++) begin
                    s = (k % 2 == 0) ? 32'(int'($urandom_range(0, 4095)) - 2048) : $urandom;
                    m = $urandom;
                    line_s[i][l*32 +: 32] = s;
                    line_m[i][l*32 +: 32] = m;
                    line_e[i][l*32 +: 32] = ref_lane(m, s, scal, int'(sh));
                end
            end
            start_op(nl, sh, off, scal, int'($urandom_range(0, 1)));
            wait_done(1'($urandom_range(0, 1)), $sformatf("rand%0d", k));
            check_op($sformatf("rand%0d", k), int'(nl), off);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pipearch_update.md
Name: pipearch_update

Overview:
- Write-side counterpart of the dot-product stage.
- Consumes one scalar per operation from the dot/scalar FIFO and streams sample lines in lockstep with model lines read from model BRAM.
- Writes the updated model back to the same BRAM: model[i] <= model[i] - ((scalar * sample[i]) >>> shift), on 16 signed 32-bit fixed-point lanes per 512-bit line.
- Sits after pipearch_dot in the SGD pipeline and is started by the instruction sequencer through op_start/regs.

Parameters:
- LANES, 16, 32-bit lanes per 512-bit line (fixed; only 16 supported).
- ADDR_W, 16, model BRAM address width.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous active-high reset.
- op_start  input  1  one-cycle start pulse; sampled only in IDLE.
- op_done  output  1  one-cycle completion pulse.
- regs0  input  32  [15:0] num_lines; [20:16] shift amount (0..31); rest ignored.
- regs1  input  32  [15:0] model BRAM base offset; rest ignored.
- samples_input  fifobram_interface.fifo_read  -  512-bit sample lines (re, rvalid, rdata, empty).
- scalar_input  fifobram_interface.fifo_read  -  32-bit scalar in rdata[31:0].
- modelMem_input  fifobram_interface.bram_read  -  model read port (re, raddr, rdata).
- modelMem_output  fifobram_interface.bram_write  -  model write port (we, waddr, wdata).

Behaviour:
- Reset: clocked state and outputs are cleared asynchronously while reset is high.
  - State = IDLE; op_done=0; all re=0; we=0; waddr=0; wdata=0; counters=0.
  - Reset mid-operation abandons the op: no further writes and no op_done. In-flight FIFO reads are discarded.
- All re strobes and op_done default to 0 every cycle; each is a single-cycle pulse when asserted.
- States: IDLE, SCALAR, STREAM, DRAIN.
- IDLE:
  - On op_start, latch num_lines, shift, offset; clear req/wr counters.
  - If num_lines==0, pulse op_done next cycle, stay IDLE, and consume no scalar.
  - Otherwise go to SCALAR.
- SCALAR:
  - When !scalar_input.empty, pulse scalar_input.re once.
  - On scalar_input.rvalid (1 cycle after re), latch rdata[31:0] as a signed scalar and go to STREAM.
- STREAM:
  - Each cycle with !samples_input.empty and req<num_lines, pulse samples_input.re and modelMem_input.re together.
  - Set raddr = offset+req (mod 2^16) and increment req.
  - When req reaches num_lines, go to DRAIN.
- Pipeline, with re at cycle T:
  - T+1: samples rvalid/rdata and modelMem rdata valid (1-cycle BRAM latency).
  - Edge ending T+1: per lane, form a 64-bit signed product of scalar and sample lane. Arithmetic right shift by shift, keep low 32 bits, subtract from the model lane (32-bit wrap). Register the result with waddr = matching raddr.
  - T+2: modelMem_output.we=1 with waddr/wdata.
  - Latency re->we is 2 cycles; throughput is 1 line/cycle.
- Addresses are strictly increasing, so read-after-write hazards cannot occur within one op.
- DRAIN:
  - When the wr counter reaches num_lines (after the last we), pulse op_done on the following cycle and return to IDLE.
- op_start outside IDLE is ignored.
- Samples FIFO going empty mid-stream stalls issue; in-flight lines still complete. No bubbles are inserted otherwise.
- Offset+req wraps at 2^16.

Optional Feature:
- PIPEARCH_UPDATE_SATURATE_EN defined:
  - The shifted product is clamped to signed 32-bit range (instead of truncated).
  - The subtraction saturates to 0x7FFFFFFF / 0x80000000 on overflow.
- Not defined: both steps wrap modulo 2^32. Latency is identical in both builds.

Test Plan:
- Basic update: num_lines=2, shift=0, offset=0x10, scalar=2; sample lanes all 3; model lanes all 10.
  - Required: writes to 0x10 and 0x11 with every lane = 4.
  - we occurs exactly 2 cycles after each re; op_done 1 cycle after the last we.
- Shift and negatives: scalar=-4, sample lane=0x100, shift=4, model=0.
  - Required: lane = 0x40, since -(-0x400>>>4)=+0x40.
- Stall: feed 4 sample lines with a 3-cycle empty gap after line 2.
  - Required: exactly 4 writes at offset..offset+3 in order; no spurious we; one op_done.
- Zero length: num_lines=0 with a scalar present.
  - Required: op_done pulse 1 cycle after op_start; scalar FIFO untouched; no re or we.
- Overflow: model=0x7FFFFFF0, scalar=-1, sample=0x20, shift=0.
  - Required: 0x80000010 without the macro; 0x7FFFFFFF with PIPEARCH_UPDATE_SATURATE_EN.
- Reset mid-op: assert reset after the 2nd of 8 writes.
  - Required: all outputs 0 immediately; no op_done.
  - A fresh op afterwards behaves exactly as the basic update case.
